// File: rtl/exp_pwl_pkg.sv
// exp_pwl_pkg -- shared definitions for the piecewise-linear 2^f evaluator.
//   coeff_t : coefficient type at the default width (Q5.26, 32 bits)
//   DEF_K   : default slopes for the 8-segment table
//   DEF_B   : default intercepts for the 8-segment table
//   sat_w   : clamps a signed value to the signed range of a w-bit word
package exp_pwl_pkg;

    localparam int W_DEF    = 32;
    localparam int Q_DEF    = 26;
    localparam int NSEG_DEF = 8;

    typedef logic signed [W_DEF-1:0] coeff_t;

    localparam coeff_t DEF_K [NSEG_DEF] = '{
        32'h02E57078, 32'h03288B9B, 32'h0371B996, 32'h03C18722,
        32'h04188DB7, 32'h047774AE, 32'h04DEF287, 32'h054FCE46
    };

    localparam coeff_t DEF_B [NSEG_DEF] = '{
        32'h04000000, 32'h03F79C9B, 32'h03E5511D, 32'h03C76408,
        32'h039BE0BD, 32'h03609063, 32'h0312F200, 32'h02B031B9
    };

    // Takes the W+2-bit sum sign-extended to 64 bits so one function serves
    // any lane width up to 62 bits; the caller keeps the low w bits.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] s,
                                                 input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)
            sat_w = hi;
        else if (s < lo)
            sat_w = lo;
        else
            sat_w = s;
    endfunction

endpackage

// File: rtl/exp_pwl_lane.sv
// exp_pwl_lane -- one datapath lane of the 2^f evaluator.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : shared stage enable (low while the output is stalled)
//   x_lane     : lane input word; only the fraction bits [Q-1:0] are used
//   k_in, b_in : coefficients already looked up for this lane's segment
//   y          : registered, rounded and saturated k*f + b
module exp_pwl_lane
    import exp_pwl_pkg::*;
#(
    parameter int W = 32,
    parameter int Q = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [W-1:0]        x_lane,
    input  logic signed [W-1:0] k_in,
    input  logic signed [W-1:0] b_in,
    output logic [W-1:0]        y
);

    localparam int PW = W + Q + 1;
    localparam logic signed [PW:0] HALF = {{(PW-Q+1){1'b0}}, 1'b1, {(Q-1){1'b0}}};

    logic [Q-1:0]         f_q,  f_d;
    logic signed [W-1:0]  k_q,  k_d;
    logic signed [W-1:0]  b1_q, b1_d;
    logic signed [PW-1:0] p_q,  p_d;
    logic signed [W-1:0]  b2_q, b2_d;
    logic [W-1:0]         y_q,  y_d;

    logic signed [PW:0]   p_rnd;
    logic signed [W+1:0]  s;
    logic                 unused_hi;

    // Integer bits of the input carry no meaning for 2^f.
    assign unused_hi = ^x_lane[W-1:Q];

    // S1 captures f and its coefficients, S2 the product, S3 the rounded,
    // biased and clamped result. Every stage advances together on en.
    always_comb begin
        f_d   = f_q;
        k_d   = k_q;
        b1_d  = b1_q;
        p_d   = p_q;
        b2_d  = b2_q;
        y_d   = y_q;
        p_rnd = (PW+1)'(p_q) + HALF;
        s     = (W+2)'(p_rnd >>> Q) + (W+2)'(b2_q);
        if (en) begin
            f_d  = x_lane[Q-1:0];
            k_d  = k_in;
            b1_d = b_in;
            // f is unsigned: a zero MSB keeps it positive in the signed multiply
            p_d  = PW'(k_q) * PW'($signed({1'b0, f_q}));
            b2_d = b1_q;
            y_d  = W'(sat_w(64'(s), W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q  <= '0;
            k_q  <= '0;
            b1_q <= '0;
            p_q  <= '0;
            b2_q <= '0;
            y_q  <= '0;
        end else begin
            f_q  <= f_d;
            k_q  <= k_d;
            b1_q <= b1_d;
            p_q  <= p_d;
            b2_q <= b2_d;
            y_q  <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/exp_pwl_pipe.sv
// exp_pwl_pipe -- pipelined multi-lane piecewise-linear 2^f, f in [0,1).
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : input handshake for the lane vector x_in
//   x_in                : NUM_PORTS packed lanes of W bits (fraction in [Q-1:0])
//   out_valid/out_ready : output handshake for y_out
//   y_out               : NUM_PORTS packed lanes, 2^f in Q format
//   cfg_we/sel/addr/data: runtime table write (sel 0 = k, 1 = b)
module exp_pwl_pipe
    import exp_pwl_pkg::*;
#(
    parameter  int W            = 32,
    parameter  int Q            = 26,
    parameter  int NUM_SEGMENTS = 8,
    parameter  int NUM_PORTS    = 32,
    localparam int SEG_BITS     = $clog2(NUM_SEGMENTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PORTS*W-1:0] x_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_PORTS*W-1:0] y_out,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [SEG_BITS-1:0]    cfg_addr,
    input  logic [W-1:0]           cfg_data
);

    localparam logic signed [W-1:0] ONE_Q = {{(W-Q-1){1'b0}}, 1'b1, {Q{1'b0}}};

    logic signed [W-1:0] k_tab_q [NUM_SEGMENTS];
    logic signed [W-1:0] k_tab_d [NUM_SEGMENTS];
    logic signed [W-1:0] b_tab_q [NUM_SEGMENTS];
    logic signed [W-1:0] b_tab_d [NUM_SEGMENTS];
    logic [2:0]          v_q, v_d;
    logic                stall;
    logic                stage_en;

    // Only a full output register that nobody takes can block the pipe, so
    // in_ready is independent of in_valid.
    assign stall     = v_q[2] & ~out_ready;
    assign stage_en  = ~stall;
    assign in_ready  = ~stall;
    assign out_valid = v_q[2];

    // Table writes ignore the stall; lanes sample the table before the
    // edge, so a lookup on the write edge still sees the old entry.
    always_comb begin
        k_tab_d = k_tab_q;
        b_tab_d = b_tab_q;
        if (cfg_we) begin
            if (cfg_sel)
                b_tab_d[cfg_addr] = cfg_data;
            else
                k_tab_d[cfg_addr] = cfg_data;
        end
    end

    always_comb begin
        v_d = v_q;
        if (stage_en)
            v_d = {v_q[1], v_q[0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                k_tab_q[i] <= (NUM_SEGMENTS == NSEG_DEF) ? W'(DEF_K[i % NSEG_DEF]) : '0;
                b_tab_q[i] <= (NUM_SEGMENTS == NSEG_DEF) ? W'(DEF_B[i % NSEG_DEF]) : ONE_Q;
            end
        end else begin
            v_q     <= v_d;
            k_tab_q <= k_tab_d;
            b_tab_q <= b_tab_d;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        logic [SEG_BITS-1:0] seg;

        // Segment index is the top SEG_BITS of the fraction.
        assign seg = x_in[g*W + Q - 1 -: SEG_BITS];

        exp_pwl_lane #(
            .W (W),
            .Q (Q)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (stage_en),
            .x_lane (x_in[g*W +: W]),
            .k_in   (k_tab_q[seg]),
            .b_in   (b_tab_q[seg]),
            .y      (y_out[g*W +: W])
        );
    end

endmodule
